// File: rtl/tank_ctrl_pkg.sv
// Shared types for the tank fill controller: FSM state encoding,
// debounced comparator flag codes and the code validity check.
package tank_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_FULL  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   // Flag pattern is {gt, eq, lt}
   localparam logic [2:0] CODE_UNK = 3'b000;
   localparam logic [2:0] CODE_LT  = 3'b001;
   localparam logic [2:0] CODE_EQ  = 3'b010;
   localparam logic [2:0] CODE_GT  = 3'b100;

   function automatic logic is_valid_code(input logic [2:0] c);
      return (c == CODE_LT) || (c == CODE_EQ) || (c == CODE_GT);
   endfunction

endpackage

// File: rtl/flag_debounce.sv
// Run-length debouncer for the comparator flag pattern; emits the
// accepted code and a single upd pulse once a run reaches DEB_CYCLES.
module flag_debounce
   import tank_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] p,
   output logic [2:0] stable,
   output logic       upd
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] C_ONE = CW'(1);
   localparam logic [CW-1:0] C_MAX = CW'(DEB_CYCLES);
   localparam logic [CW-1:0] C_PRE = CW'(DEB_CYCLES - 1);

   logic [2:0]    r_prev;
   logic [2:0]    r_stable;
   logic [CW-1:0] r_cnt;
   logic          r_upd;

   logic w_same;
   logic w_hit;

   assign w_same = (p == r_prev);
   // Counter saturates at C_MAX, so the hit happens once per run
   assign w_hit  = w_same && (r_cnt == C_PRE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev   <= CODE_UNK;
         r_stable <= CODE_UNK;
         r_cnt    <= '0;
         r_upd    <= 1'b0;
      end else begin
         r_prev <= p;
         r_upd  <= w_hit;
         if (!w_same) begin
            r_cnt <= C_ONE;
         end else if (r_cnt != C_MAX) begin
            r_cnt <= r_cnt + C_ONE;
         end
         if (w_hit) begin
            r_stable <= p;
         end
      end
   end

   assign stable = r_stable;
   assign upd    = r_upd;

endmodule

// File: rtl/tank_fill_controller.sv
// Fill/drain valve controller: debounced level flags drive a Moore FSM
// with per-state timeout and a sticky overshoot/fault alarm.
module tank_fill_controller
   import tank_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES    = 4,
   parameter int FILL_TIMEOUT  = 200,
   parameter int DRAIN_TIMEOUT = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       lt,
   input  logic       eq,
   input  logic       gt,
   input  logic       ack,
   output logic       valve,
   output logic       drain,
   output logic       alarm,
   output logic       fault,
   output logic [2:0] state
);

   localparam int TMAX =
      (FILL_TIMEOUT > DRAIN_TIMEOUT) ? FILL_TIMEOUT : DRAIN_TIMEOUT;
   localparam int TW = $clog2(TMAX);
   localparam logic [TW-1:0] T_ONE     = TW'(1);
   localparam logic [TW-1:0] FILL_LIM  = TW'(FILL_TIMEOUT - 1);
   localparam logic [TW-1:0] DRAIN_LIM = TW'(DRAIN_TIMEOUT - 1);

   logic [2:0]    w_pat;
   logic [2:0]    w_stable;
   logic          w_upd;
   logic          w_inv;
   logic          w_fill_to;
   logic          w_drain_to;
   logic          w_over;
   logic          w_set;
   logic          w_timing;

   state_t        r_state;
   state_t        w_next;
   logic [TW-1:0] r_tmr;
   logic          r_alarm;

   assign w_pat = {gt, eq, lt};

   flag_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .p     (w_pat),
      .stable(w_stable),
      .upd   (w_upd)
   );

   // UNK is neither valid nor a fault trigger
   assign w_inv = w_upd
                  && !is_valid_code(w_stable)
                  && (w_stable != CODE_UNK);

   assign w_fill_to  = (r_tmr == FILL_LIM);
   assign w_drain_to = (r_tmr == DRAIN_LIM);

   always_comb begin
      w_next = r_state;
      w_over = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_inv) begin
               w_next = ST_FAULT;
            end else if (en && (w_stable == CODE_LT)) begin
               w_next = ST_FILL;
            end else if (en && (w_stable == CODE_GT)) begin
               w_next = ST_DRAIN;
            end
         end
         ST_FILL: begin
            if (w_inv || w_fill_to) begin
               w_next = ST_FAULT;
            end else if (!en) begin
               w_next = ST_IDLE;
            end else if (w_stable == CODE_EQ) begin
               w_next = ST_FULL;
            end else if (w_stable == CODE_GT) begin
               w_next = ST_DRAIN;
               w_over = 1'b1;
            end
         end
         ST_FULL: begin
            if (w_inv) begin
               w_next = ST_FAULT;
            end else if (!en) begin
               w_next = ST_IDLE;
            end else if (w_stable == CODE_LT) begin
               w_next = ST_FILL;
            end else if (w_stable == CODE_GT) begin
               w_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_inv || w_drain_to) begin
               w_next = ST_FAULT;
            end else if (!en) begin
               w_next = ST_IDLE;
            end else if (w_stable == CODE_EQ) begin
               w_next = ST_FULL;
            end else if (w_stable == CODE_LT) begin
               w_next = ST_FILL;
            end
         end
         ST_FAULT: begin
            if (ack) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_FAULT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   assign w_timing = (r_state == ST_FILL) || (r_state == ST_DRAIN);

   // Saturating count; the timeout compare fires before the top
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmr <= '0;
      end else if ((w_next != r_state) || !w_timing) begin
         r_tmr <= '0;
      end else if (r_tmr != '1) begin
         r_tmr <= r_tmr + T_ONE;
      end
   end

   assign w_set = w_over
                  || ((w_next == ST_FAULT) && (r_state != ST_FAULT));

   // A new set beats a simultaneous ack
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alarm <= 1'b0;
      end else if (w_set) begin
         r_alarm <= 1'b1;
      end else if (ack) begin
         r_alarm <= 1'b0;
      end
   end

   assign valve = (r_state == ST_FILL);
   assign drain = (r_state == ST_DRAIN);
   assign fault = (r_state == ST_FAULT);
   assign alarm = r_alarm;
   assign state = r_state;

endmodule

// File: tb/tb_tank_fill_controller.sv
// Scenario bench for tank_fill_controller: each entry queues stimulus,
// a cycle count and the expected {state,valve,drain,alarm,fault}.
module tb_tank_fill_controller;
   import tank_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       lt;
   logic       eq;
   logic       gt;
   logic       ack;
   logic       valve;
   logic       drain;
   logic       alarm;
   logic       fault;
   logic [2:0] state;

   always #5 clk = ~clk;

   tank_fill_controller #(
      .DEB_CYCLES   (4),
      .FILL_TIMEOUT (20),
      .DRAIN_TIMEOUT(30)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .lt   (lt),
      .eq   (eq),
      .gt   (gt),
      .ack  (ack),
      .valve(valve),
      .drain(drain),
      .alarm(alarm),
      .fault(fault),
      .state(state)
   );

   typedef struct packed {
      logic       r;
      logic       e;
      logic       a;
      logic [2:0] p;
      int         cyc;
      logic [6:0] exp;
   } ent_t;

   ent_t  sb[$];
   string nq[$];
   int    checks = 0;
   int    passed = 0;

   localparam logic [2:0] P_NONE = 3'b000;
   localparam logic [2:0] P_LT   = 3'b001;
   localparam logic [2:0] P_EQ   = 3'b010;
   localparam logic [2:0] P_GT   = 3'b100;
   localparam logic [2:0] P_BAD  = 3'b110;

   function automatic logic [6:0] pk(input logic [2:0] s,
                                     input logic v, input logic d,
                                     input logic a, input logic f);
      return {s, v, d, a, f};
   endfunction

   function automatic logic [6:0] outs();
      return {state, valve, drain, alarm, fault};
   endfunction

   task automatic push(input string n, input logic r, input logic e,
                       input logic a, input logic [2:0] p,
                       input int c, input logic [6:0] x);
      ent_t t;
      t.r = r; t.e = e; t.a = a; t.p = p; t.cyc = c; t.exp = x;
      sb.push_back(t);
      nq.push_back(n);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input ent_t t);
      rst = t.r; en = t.e; ack = t.a;
      {gt, eq, lt} = t.p;
   endtask

   task automatic test_reset();
      ent_t  c;
      string n;
      push("reset",      1, 0, 0, P_NONE, 2, pk(ST_IDLE, 0, 0, 0, 0));
      push("idle_unk",   0, 0, 0, P_NONE, 5, pk(ST_IDLE, 0, 0, 0, 0));
      while (sb.size() > 0) begin
         c = sb.pop_front(); n = nq.pop_front();
         apply(c);
         repeat (c.cyc) step();
         checks++;
         if (outs() !== c.exp)
            $display("FAIL %s: got %b want %b", n, outs(), c.exp);
         else passed++;
      end
   endtask

   task automatic test_fill_entry();
      ent_t  c;
      string n;
      push("lt_wait",    0, 1, 0, P_LT, 4, pk(ST_IDLE, 0, 0, 0, 0));
      push("fill_entry", 0, 1, 0, P_LT, 1, pk(ST_FILL, 1, 0, 0, 0));
      push("fill_hold",  0, 1, 0, P_LT, 5, pk(ST_FILL, 1, 0, 0, 0));
      push("eq_wait",    0, 1, 0, P_EQ, 4, pk(ST_FILL, 1, 0, 0, 0));
      push("full_entry", 0, 1, 0, P_EQ, 1, pk(ST_FULL, 0, 0, 0, 0));
      push("gt_glitch",  0, 1, 0, P_GT, 3, pk(ST_FULL, 0, 0, 0, 0));
      push("glitch_gone",0, 1, 0, P_EQ, 5, pk(ST_FULL, 0, 0, 0, 0));
      while (sb.size() > 0) begin
         c = sb.pop_front(); n = nq.pop_front();
         apply(c);
         repeat (c.cyc) step();
         checks++;
         if (outs() !== c.exp)
            $display("FAIL %s: got %b want %b", n, outs(), c.exp);
         else passed++;
      end
   endtask

   task automatic test_overshoot();
      ent_t  c;
      string n;
      push("refill_wait",0, 1, 0, P_LT, 4, pk(ST_FULL, 0, 0, 0, 0));
      push("refill",     0, 1, 0, P_LT, 1, pk(ST_FILL, 1, 0, 0, 0));
      push("gt_wait",    0, 1, 0, P_GT, 4, pk(ST_FILL, 1, 0, 0, 0));
      push("overshoot",  0, 1, 0, P_GT, 1, pk(ST_DRAIN, 0, 1, 1, 0));
      push("ack_clear",  0, 1, 1, P_GT, 1, pk(ST_DRAIN, 0, 1, 0, 0));
      push("eq_drain",   0, 1, 0, P_EQ, 5, pk(ST_FULL, 0, 0, 0, 0));
      while (sb.size() > 0) begin
         c = sb.pop_front(); n = nq.pop_front();
         apply(c);
         repeat (c.cyc) step();
         checks++;
         if (outs() !== c.exp)
            $display("FAIL %s: got %b want %b", n, outs(), c.exp);
         else passed++;
      end
   endtask

   task automatic test_timeout();
      ent_t  c;
      string n;
      push("lt_refill",  0, 1, 0, P_LT, 5,  pk(ST_FILL, 1, 0, 0, 0));
      push("fill_19",    0, 1, 0, P_LT, 19, pk(ST_FILL, 1, 0, 0, 0));
      push("fill_tmo",   0, 1, 0, P_LT, 1,  pk(ST_FAULT, 0, 0, 1, 1));
      push("fault_hold", 0, 1, 0, P_LT, 3,  pk(ST_FAULT, 0, 0, 1, 1));
      push("ack_exit",   0, 0, 1, P_LT, 1,  pk(ST_IDLE, 0, 0, 0, 0));
      push("idle_stay",  0, 0, 0, P_LT, 2,  pk(ST_IDLE, 0, 0, 0, 0));
      while (sb.size() > 0) begin
         c = sb.pop_front(); n = nq.pop_front();
         apply(c);
         repeat (c.cyc) step();
         checks++;
         if (outs() !== c.exp)
            $display("FAIL %s: got %b want %b", n, outs(), c.exp);
         else passed++;
      end
   endtask

   task automatic test_inv_fault();
      ent_t  c;
      string n;
      push("relaunch",   0, 1, 0, P_LT,  1, pk(ST_FILL, 1, 0, 0, 0));
      push("eq_full",    0, 1, 0, P_EQ,  5, pk(ST_FULL, 0, 0, 0, 0));
      push("inv_wait",   0, 1, 0, P_BAD, 4, pk(ST_FULL, 0, 0, 0, 0));
      push("inv_fault",  0, 1, 0, P_EQ,  1, pk(ST_FAULT, 0, 0, 1, 1));
      push("inv_ack",    0, 0, 1, P_EQ,  1, pk(ST_IDLE, 0, 0, 0, 0));
      while (sb.size() > 0) begin
         c = sb.pop_front(); n = nq.pop_front();
         apply(c);
         repeat (c.cyc) step();
         checks++;
         if (outs() !== c.exp)
            $display("FAIL %s: got %b want %b", n, outs(), c.exp);
         else passed++;
      end
   endtask

   task automatic test_ack_overshoot();
      ent_t  c;
      string n;
      push("lt_arm",     0, 0, 0, P_LT, 5, pk(ST_IDLE, 0, 0, 0, 0));
      push("go_fill",    0, 1, 0, P_LT, 1, pk(ST_FILL, 1, 0, 0, 0));
      push("gt_arm",     0, 1, 0, P_GT, 4, pk(ST_FILL, 1, 0, 0, 0));
      push("ack_vs_set", 0, 1, 1, P_GT, 1, pk(ST_DRAIN, 0, 1, 1, 0));
      push("alarm_kept", 0, 1, 0, P_GT, 1, pk(ST_DRAIN, 0, 1, 1, 0));
      while (sb.size() > 0) begin
         c = sb.pop_front(); n = nq.pop_front();
         apply(c);
         repeat (c.cyc) step();
         checks++;
         if (outs() !== c.exp)
            $display("FAIL %s: got %b want %b", n, outs(), c.exp);
         else passed++;
      end
   endtask

   task automatic test_en_drop();
      ent_t  c;
      string n;
      push("en_drop",    0, 0, 0, P_GT, 1, pk(ST_IDLE, 0, 0, 1, 0));
      while (sb.size() > 0) begin
         c = sb.pop_front(); n = nq.pop_front();
         apply(c);
         repeat (c.cyc) step();
         checks++;
         if (outs() !== c.exp)
            $display("FAIL %s: got %b want %b", n, outs(), c.exp);
         else passed++;
      end
   endtask

   task automatic test_rst_mid_fill();
      ent_t  c;
      string n;
      push("lt_rearm",   0, 0, 0, P_LT, 5, pk(ST_IDLE, 0, 0, 1, 0));
      push("fill_again", 0, 1, 0, P_LT, 1, pk(ST_FILL, 1, 0, 1, 0));
      push("rst_mid",    1, 1, 0, P_LT, 1, pk(ST_IDLE, 0, 0, 0, 0));
      push("post_rst_w", 0, 1, 0, P_LT, 4, pk(ST_IDLE, 0, 0, 0, 0));
      push("post_rst_f", 0, 1, 0, P_LT, 1, pk(ST_FILL, 1, 0, 0, 0));
      while (sb.size() > 0) begin
         c = sb.pop_front(); n = nq.pop_front();
         apply(c);
         repeat (c.cyc) step();
         checks++;
         if (outs() !== c.exp)
            $display("FAIL %s: got %b want %b", n, outs(), c.exp);
         else passed++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; en = 1'b0; ack = 1'b0;
      lt = 1'b0; eq = 1'b0; gt = 1'b0;
      test_reset();
      test_fill_entry();
      test_overshoot();
      test_timeout();
      test_inv_fault();
      test_ack_overshoot();
      test_en_drop();
      test_rst_mid_fill();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
